move_gen: RTL

MOVE_GEN -- requirements
Module: move_gen

---
 rtl/move_gen.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/move_gen.sv
// move_gen: pseudo-legal move scanner for a single chess piece.
//
// On an accepted start the selected square and a full copy of the board are
// latched; the scan then walks the piece's candidate targets one per cycle
// and builds a 64-bit target bitboard.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        scan request, only honoured while idle
//   square       selected square index (rank*8 + file)
//   board        4-bit piece code per square, square s at [4s+3:4s]
//   move_options target bitboard of the last scan
//   valid        move_options holds a completed result
//   busy         scan in progress
//   done         one-cycle pulse when valid rises
module move_gen (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [5:0]   square,
    input  logic [255:0] board,
    output logic [63:0]  move_options,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, DECODE, STEP, DONE} state_t;

    state_t              state;
    logic [5:0]          sq_reg;
    logic [255:0]        board_reg;
    logic [3:0]          cand;
    logic signed [4:0]   cur_r;
    logic signed [4:0]   cur_f;

    // Direction index 0..7 = N, NE, E, SE, S, SW, W, NW.
    function automatic logic signed [4:0] dir_dr(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd7: dir_dr = 5'sd1;
            3'd3, 3'd4, 3'd5: dir_dr = -5'sd1;
            default:          dir_dr = 5'sd0;
        endcase
    endfunction

    function automatic logic signed [4:0] dir_df(input logic [2:0] i);
        case (i)
            3'd1, 3'd2, 3'd3: dir_df = 5'sd1;
            3'd5, 3'd6, 3'd7: dir_df = -5'sd1;
            default:          dir_df = 5'sd0;
        endcase
    endfunction

    function automatic logic signed [4:0] kn_dr(input logic [2:0] i);
        case (i)
            3'd0, 3'd7: kn_dr = 5'sd2;
            3'd1, 3'd6: kn_dr = 5'sd1;
            3'd2, 3'd5: kn_dr = -5'sd1;
            default:    kn_dr = -5'sd2;
        endcase
    endfunction

    function automatic logic signed [4:0] kn_df(input logic [2:0] i);
        case (i)
            3'd1, 3'd2: kn_df = 5'sd2;
            3'd0, 3'd3: kn_df = 5'sd1;
            3'd4, 3'd7: kn_df = -5'sd1;
            default:    kn_df = -5'sd2;
        endcase
    endfunction

    // Selected piece, always taken from the latched board copy.
    logic [3:0]        own_piece;
    logic [2:0]        own_type;
    logic              own_col;
    logic              is_slider;
    logic              is_empty_sel;
    logic signed [4:0] sq_r;
    logic signed [4:0] sq_f;
    logic signed [4:0] fwd;

    assign own_piece    = board_reg[{sq_reg, 2'b00} +: 4];
    assign own_type     = own_piece[2:0];
    assign own_col      = own_piece[3];
    assign is_slider    = (own_type == 3'd3) || (own_type == 3'd4) || (own_type == 3'd5);
    assign is_empty_sel = (own_type == 3'd0) || (own_type == 3'd7);
    assign sq_r         = $signed({2'b00, sq_reg[5:3]});
    assign sq_f         = $signed({2'b00, sq_reg[2:0]});
    assign fwd          = own_col ? -5'sd1 : 5'sd1;

    // Current candidate evaluation.
    logic signed [4:0] dr, df, base_r, base_f, tgt_r, tgt_f;
    logic              on_board;
    logic [5:0]        tgt_idx;
    logic [3:0]        tgt_piece;
    logic              tgt_empty, tgt_own, tgt_enemy;
    logic [5:0]        mid_idx;
    logic [3:0]        mid_piece;
    logic              mid_empty, start_rank;
    logic              hit;
    logic [3:0]        dir_step;
    logic [3:0]        next_dir;

    always_comb begin
        dr     = 5'sd0;
        df     = 5'sd0;
        base_r = sq_r;
        base_f = sq_f;
        case (own_type)
            3'd1: begin
                dr = (cand[1:0] == 2'd1) ? (fwd <<< 1) : fwd;
                df = (cand[1:0] == 2'd2) ? -5'sd1 : ((cand[1:0] == 2'd3) ? 5'sd1 : 5'sd0);
            end
            3'd2: begin
                dr = kn_dr(cand[2:0]);
                df = kn_df(cand[2:0]);
            end
            3'd3, 3'd4, 3'd5: begin
                base_r = cur_r;
                base_f = cur_f;
                dr     = dir_dr(cand[2:0]);
                df     = dir_df(cand[2:0]);
            end
            3'd6: begin
                dr = dir_dr(cand[2:0]);
                df = dir_df(cand[2:0]);
            end
            default: ;
        endcase
        tgt_r = base_r + dr;
        tgt_f = base_f + df;
    end

    // In range 0..7 exactly when the two top bits of the signed value are zero.
    assign on_board  = (tgt_r[4:3] == 2'b00) && (tgt_f[4:3] == 2'b00);
    assign tgt_idx   = {tgt_r[2:0], tgt_f[2:0]};
    assign tgt_piece = board_reg[{tgt_idx, 2'b00} +: 4];
    assign tgt_empty = (tgt_piece[2:0] == 3'd0) || (tgt_piece[2:0] == 3'd7);
    assign tgt_own   = !tgt_empty && (tgt_piece[3] == own_col);
    assign tgt_enemy = !tgt_empty && (tgt_piece[3] != own_col);

    // Intermediate square of a double push; only consulted on the start rank.
    assign start_rank = (sq_reg[5:3] == (own_col ? 3'd6 : 3'd1));
    assign mid_idx    = {(own_col ? 3'd5 : 3'd2), sq_reg[2:0]};
    assign mid_piece  = board_reg[{mid_idx, 2'b00} +: 4];
    assign mid_empty  = (mid_piece[2:0] == 3'd0) || (mid_piece[2:0] == 3'd7);

    always_comb begin
        if (own_type == 3'd1) begin
            case (cand[1:0])
                2'd0:    hit = on_board && tgt_empty;
                2'd1:    hit = on_board && start_rank && mid_empty && tgt_empty;
                default: hit = on_board && tgt_enemy;
            endcase
        end else begin
            hit = on_board && !tgt_own;
        end
    end

    // Rook and bishop visit every other direction, the queen all of them.
    assign dir_step = (own_type == 3'd5) ? 4'd1 : 4'd2;
    assign next_dir = cand + dir_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sq_reg       <= '0;
            board_reg    <= '0;
            cand         <= '0;
            cur_r        <= '0;
            cur_f        <= '0;
            move_options <= '0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sq_reg       <= square;
                        board_reg    <= board;
                        move_options <= '0;
                        valid        <= 1'b0;
                        busy         <= 1'b1;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    cand  <= (own_type == 3'd3) ? 4'd1 : 4'd0;
                    cur_r <= sq_r;
                    cur_f <= sq_f;
                    state <= is_empty_sel ? DONE : STEP;
                end
                STEP: begin
                    if (hit)
                        move_options[tgt_idx] <= 1'b1;
                    if (is_slider) begin
                        if (on_board && tgt_empty) begin
                            // Ray continues through an empty square.
                            cur_r <= tgt_r;
                            cur_f <= tgt_f;
                        end else begin
                            cur_r <= sq_r;
                            cur_f <= sq_f;
                            cand  <= next_dir;
                            if (next_dir[3])
                                state <= DONE;
                        end
                    end else begin
                        cand <= cand + 4'd1;
                        if (cand == ((own_type == 3'd1) ? 4'd3 : 4'd7))
                            state <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
